// File: rtl/apb_mem_slave.sv
// APB4 completer backed by a word-addressed memory, with programmable
// wait states, byte strobes, a PPROT-guarded secure region and error replies.
module apb_mem_slave #(
    parameter int ADDR_WIDTH   = 16,
    parameter int DATA_WIDTH   = 32,
    parameter int MEM_DEPTH    = 1024,
    parameter int WAIT_CYCLES  = 1,
    parameter int SECURE_WORDS = 16
) (
    input  logic                    PCLK,
    input  logic                    PRESETn,
    input  logic                    PCLKEN,
    input  logic                    PSEL,
    input  logic                    PENABLE,
    input  logic                    PWRITE,
    input  logic [ADDR_WIDTH-1:0]   PADDR,
    input  logic [DATA_WIDTH-1:0]   PWDATA,
    input  logic [DATA_WIDTH/8-1:0] PSTRB,
    input  logic [2:0]              PPROT,
    output logic                    PREADY,
    output logic [DATA_WIDTH-1:0]   PRDATA,
    output logic                    PSLVERR
);

    localparam int IW = ADDR_WIDTH - 2;
    localparam int MW = $clog2(MEM_DEPTH);
    localparam int SW = DATA_WIDTH / 8;

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [IW-1:0]       idx_q;
    logic                wr_q, err_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [SW-1:0]       strb_q;

    logic                ready_d, slverr_d, commit, setup;
    logic [DATA_WIDTH-1:0] rdata_d;
    logic [IW-1:0]       idx_in;
    logic                err_in;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    assign idx_in = PADDR[ADDR_WIDTH-1:2];
    assign setup  = (state_q == IDLE) && PSEL && !PENABLE;

    // Any single violation turns the transfer into an error reply
    assign err_in = (PADDR[1:0] != 2'b00)
                 || (32'(idx_in) >= MEM_DEPTH)
                 || (PPROT[1] && (32'(idx_in) < SECURE_WORDS))
                 || (!PWRITE && (PSTRB != '0));

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            PREADY  <= 1'b0;
            PRDATA  <= '0;
            PSLVERR <= 1'b0;
        end else if (PCLKEN) begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            PREADY  <= ready_d;
            PRDATA  <= rdata_d;
            PSLVERR <= slverr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (PSEL && !PENABLE) begin
                    state_d = ACCESS;
                    cnt_d   = 4'(WAIT_CYCLES);
                end
            end
            ACCESS: begin
                if (!PSEL || (PREADY && PENABLE)) begin
                    state_d = IDLE;
                end else if (PENABLE && (cnt_q != 4'd0)) begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
        endcase
    end

    always_comb begin
        ready_d  = PREADY;
        slverr_d = PSLVERR;
        rdata_d  = PRDATA;
        commit   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (PSEL && !PENABLE && (WAIT_CYCLES == 0)) begin
                    ready_d  = 1'b1;
                    slverr_d = err_in;
                    rdata_d  = (!PWRITE && !err_in) ? mem[idx_in[MW-1:0]] : '0;
                end
            end
            ACCESS: begin
                if (!PSEL) begin
                    ready_d  = 1'b0;
                    slverr_d = 1'b0;
                    rdata_d  = '0;
                end else if (PREADY && PENABLE) begin
                    commit   = wr_q && !err_q;
                    ready_d  = 1'b0;
                    slverr_d = 1'b0;
                    rdata_d  = '0;
                end else if (PENABLE && (cnt_q == 4'd1)) begin
                    ready_d  = 1'b1;
                    slverr_d = err_q;
                    rdata_d  = (!wr_q && !err_q) ? mem[idx_q[MW-1:0]] : '0;
                end
            end
        endcase
    end

    // Transfer attributes are captured once; access-phase bus changes are ignored
    always_ff @(posedge PCLK) begin
        if (PRESETn && PCLKEN && setup) begin
            idx_q   <= idx_in;
            wr_q    <= PWRITE;
            err_q   <= err_in;
            wdata_q <= PWDATA;
            strb_q  <= PSTRB;
        end
    end

    always_ff @(posedge PCLK) begin
        if (PRESETn && PCLKEN && commit) begin
            for (int i = 0; i < SW; i++) begin
                if (strb_q[i]) begin
                    mem[idx_q[MW-1:0]][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_apb_mem_slave.sv
// Self-checking bench for apb_mem_slave: directed scenarios plus randomized
// transfers compared against an associative-array memory model.
module tb_apb_mem_slave;

    localparam int WAITS = 1;

    logic        PCLK = 1'b0;
    logic        PRESETn, PCLKEN, PSEL, PENABLE, PWRITE;
    logic [15:0] PADDR;
    logic [31:0] PWDATA;
    logic [3:0]  PSTRB;
    logic [2:0]  PPROT;
    logic        PREADY;
    logic [31:0] PRDATA;
    logic        PSLVERR;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [31:0] mem_m [int];

    apb_mem_slave #(
        .ADDR_WIDTH(16), .DATA_WIDTH(32), .MEM_DEPTH(1024),
        .WAIT_CYCLES(WAITS), .SECURE_WORDS(16)
    ) dut (
        .PCLK(PCLK), .PRESETn(PRESETn), .PCLKEN(PCLKEN),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB), .PPROT(PPROT),
        .PREADY(PREADY), .PRDATA(PRDATA), .PSLVERR(PSLVERR)
    );

    always #5 PCLK = ~PCLK;
    always @(posedge PCLK) cyc <= cyc + 1;

    function automatic bit exp_err(input logic wr, input logic [15:0] a,
                                   input logic [3:0] s, input logic [2:0] p);
        int idx = int'(a) / 4;
        return (int'(a) % 4 != 0) || (idx >= 1024) ||
               (p[1] && idx < 16) || (!wr && s != 4'h0);
    endfunction

    function automatic void model_write(input int idx, input logic [31:0] d,
                                        input logic [3:0] s);
        logic [31:0] w = mem_m.exists(idx) ? mem_m[idx] : 32'h0;
        for (int i = 0; i < 4; i++)
            if (s[i]) w[8*i +: 8] = d[8*i +: 8];
        mem_m[idx] = w;
    endfunction

    // Starts just after a rising edge; returns just after the completion edge.
    task automatic apb_xfer(input logic wr, input logic [15:0] a,
                            input logic [31:0] wd, input logic [3:0] s,
                            input logic [2:0] p, output logic [31:0] rd,
                            output logic err, output int waits);
        PSEL = 1; PENABLE = 0; PWRITE = wr; PADDR = a;
        PWDATA = wd; PSTRB = s; PPROT = p;
        @(posedge PCLK); #1;
        PENABLE = 1;
        PADDR = 16'($urandom);
        PWDATA = $urandom;
        waits = 0; rd = '0; err = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge PCLK);
            if (PREADY) begin
                rd = PRDATA; err = PSLVERR;
                break;
            end
            waits++;
        end
        if (waits >= 40) begin
            checks++; failures++;
            $display("FAIL xfer_timeout addr=%h got no PREADY in 40 cycles", a);
        end
        @(posedge PCLK); #1;
        PSEL = 0; PENABLE = 0;
    endtask

    task automatic test_reset;
        PRESETn = 0; PCLKEN = 1; PSEL = 1; PENABLE = 0; PWRITE = 1;
        PADDR = 16'h0040; PWDATA = 32'h0; PSTRB = 4'hF; PPROT = 3'b000;
        repeat (3) begin
            @(posedge PCLK); @(negedge PCLK);
            checks++;
            if ({PREADY, PSLVERR, PRDATA} !== 34'h0) begin
                failures++;
                $display("FAIL reset_outputs got rdy=%b err=%b rd=%h want 0/0/0",
                         PREADY, PSLVERR, PRDATA);
            end
        end
        @(posedge PCLK); #1;
        PRESETn = 1; PSEL = 0;
        @(negedge PCLK);
        checks++;
        if (PREADY !== 1'b0) begin
            failures++;
            $display("FAIL reset_release_ready got %b want 0", PREADY);
        end
        @(posedge PCLK); #1;
    endtask

    task automatic test_write_read;
        logic [31:0] rd; logic e; int w;
        apb_xfer(1, 16'h0040, 32'hDEADBEEF, 4'hF, 3'b000, rd, e, w);
        model_write(16, 32'hDEADBEEF, 4'hF);
        checks++;
        if (w !== WAITS || e !== 1'b0) begin
            failures++;
            $display("FAIL wr_basic got waits=%0d err=%b want %0d/0", w, e, WAITS);
        end
        apb_xfer(0, 16'h0040, 32'h0, 4'h0, 3'b000, rd, e, w);
        checks++;
        if (rd !== 32'hDEADBEEF || e !== 1'b0 || w !== WAITS) begin
            failures++;
            $display("FAIL rd_basic got %h err=%b waits=%0d want deadbeef/0/%0d",
                     rd, e, w, WAITS);
        end
    endtask

    task automatic test_strobes;
        logic [31:0] rd; logic e; int w;
        apb_xfer(1, 16'h0040, 32'h11223344, 4'b0101, 3'b000, rd, e, w);
        model_write(16, 32'h11223344, 4'b0101);
        apb_xfer(0, 16'h0040, 32'h0, 4'h0, 3'b000, rd, e, w);
        checks++;
        if (rd !== 32'hDE22BE44) begin
            failures++;
            $display("FAIL strobe_merge got %h want de22be44", rd);
        end
        apb_xfer(1, 16'h0040, 32'hFFFFFFFF, 4'h0, 3'b000, rd, e, w);
        checks++;
        if (e !== 1'b0) begin
            failures++;
            $display("FAIL strobe_zero_err got %b want 0", e);
        end
        apb_xfer(0, 16'h0040, 32'h0, 4'h0, 3'b000, rd, e, w);
        checks++;
        if (rd !== 32'hDE22BE44) begin
            failures++;
            $display("FAIL strobe_zero_mem got %h want de22be44", rd);
        end
    endtask

    task automatic test_errors;
        logic [31:0] rd; logic e; int w;
        logic [15:0] ad [4] = '{16'h0042, 16'h1000, 16'h0008, 16'h0040};
        logic        wr [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        logic [3:0]  st [4] = '{4'hF, 4'hF, 4'hF, 4'h1};
        logic [2:0]  pr [4] = '{3'b000, 3'b000, 3'b010, 3'b000};
        logic [15:0] ck [4] = '{16'h0040, 16'h0000, 16'h0008, 16'h0040};
        apb_xfer(1, 16'h0000, 32'h0BADF00D, 4'hF, 3'b000, rd, e, w);
        model_write(0, 32'h0BADF00D, 4'hF);
        apb_xfer(1, 16'h0008, 32'hA5A50008, 4'hF, 3'b000, rd, e, w);
        model_write(2, 32'hA5A50008, 4'hF);
        for (int i = 0; i < 4; i++) begin
            apb_xfer(wr[i], ad[i], 32'h5A5A5A5A, st[i], pr[i], rd, e, w);
            checks++;
            if (e !== 1'b1 || w !== WAITS || rd !== 32'h0) begin
                failures++;
                $display("FAIL err_case%0d got err=%b waits=%0d rd=%h want 1/%0d/0",
                         i, e, w, rd, WAITS);
            end
            apb_xfer(0, ck[i], 32'h0, 4'h0, 3'b000, rd, e, w);
            checks++;
            if (rd !== mem_m[int'(ck[i]) / 4] || e !== 1'b0) begin
                failures++;
                $display("FAIL err_case%0d_mem got %h want %h", i, rd,
                         mem_m[int'(ck[i]) / 4]);
            end
        end
    endtask

    task automatic test_abort;
        logic [31:0] rd; logic e; int w;
        apb_xfer(1, 16'h0080, 32'h80808080, 4'hF, 3'b000, rd, e, w);
        model_write(32, 32'h80808080, 4'hF);
        PSEL = 1; PENABLE = 0; PWRITE = 1; PADDR = 16'h0080;
        PWDATA = 32'h12345678; PSTRB = 4'hF; PPROT = 3'b000;
        @(posedge PCLK); #1;
        PENABLE = 1;
        @(negedge PCLK);
        PSEL = 0; PENABLE = 0;
        @(posedge PCLK); @(negedge PCLK);
        checks++;
        if (PREADY !== 1'b0) begin
            failures++;
            $display("FAIL abort_ready got %b want 0", PREADY);
        end
        @(posedge PCLK); #1;
        apb_xfer(0, 16'h0080, 32'h0, 4'h0, 3'b000, rd, e, w);
        checks++;
        if (rd !== 32'h80808080 || w !== WAITS) begin
            failures++;
            $display("FAIL abort_nocommit got %h waits=%0d want 80808080/%0d",
                     rd, w, WAITS);
        end
        PSEL = 1; PENABLE = 0; PWRITE = 1; PADDR = 16'h0080;
        PWDATA = 32'hCAFEF00D; PSTRB = 4'hF; PPROT = 3'b000;
        @(posedge PCLK); #1;
        PENABLE = 1;
        @(negedge PCLK);
        PRESETn = 0; PSEL = 0; PENABLE = 0;
        @(posedge PCLK); #1;
        PRESETn = 1;
        @(negedge PCLK);
        checks++;
        if (PREADY !== 1'b0) begin
            failures++;
            $display("FAIL midreset_ready got %b want 0", PREADY);
        end
        @(posedge PCLK); #1;
        apb_xfer(0, 16'h0080, 32'h0, 4'h0, 3'b000, rd, e, w);
        checks++;
        if (rd !== 32'h80808080) begin
            failures++;
            $display("FAIL midreset_nocommit got %h want 80808080", rd);
        end
    endtask

    task automatic test_clken;
        logic [31:0] rd, v; logic e; int w;
        v = $urandom;
        PSEL = 1; PENABLE = 0; PWRITE = 1; PADDR = 16'h0084;
        PWDATA = v; PSTRB = 4'hF; PPROT = 3'b000;
        @(posedge PCLK); #1;
        PENABLE = 1; PCLKEN = 0;
        w = 0;
        repeat (5) begin
            @(negedge PCLK);
            if (!PREADY) w++;
            @(posedge PCLK);
        end
        #1 PCLKEN = 1;
        for (int i = 0; i < 40; i++) begin
            @(negedge PCLK);
            if (PREADY) break;
            w++;
        end
        checks++;
        if (w !== WAITS + 5) begin
            failures++;
            $display("FAIL clken_shift got waits=%0d want %0d", w, WAITS + 5);
        end
        PCLKEN = 0;
        @(posedge PCLK); @(negedge PCLK);
        checks++;
        if (PREADY !== 1'b1) begin
            failures++;
            $display("FAIL clken_hold_ready got %b want 1", PREADY);
        end
        PCLKEN = 1;
        @(posedge PCLK); #1;
        PSEL = 0; PENABLE = 0;
        model_write(33, v, 4'hF);
        apb_xfer(0, 16'h0084, 32'h0, 4'h0, 3'b000, rd, e, w);
        checks++;
        if (rd !== v) begin
            failures++;
            $display("FAIL clken_commit got %h want %h", rd, v);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] rd, v; logic e; int w, t0;
        t0 = cyc;
        for (int i = 0; i < 4; i++) begin
            v = $urandom;
            apb_xfer(1, 16'(64 + 4 * i), v, 4'hF, 3'b000, rd, e, w);
            model_write(16 + i, v, 4'hF);
            apb_xfer(0, 16'(64 + 4 * i), 32'h0, 4'h0, 3'b000, rd, e, w);
            checks++;
            if (rd !== v) begin
                failures++;
                $display("FAIL b2b_raw%0d got %h want %h", i, rd, v);
            end
        end
        checks++;
        if (cyc - t0 !== 8 * (2 + WAITS)) begin
            failures++;
            $display("FAIL b2b_cycles got %0d want %0d", cyc - t0, 8 * (2 + WAITS));
        end
    endtask

    task automatic test_random;
        logic [31:0] rd, d, want; logic e, wr, xe; int w, r;
        logic [15:0] a; logic [3:0] s; logic [2:0] p;
        for (int i = 0; i < 32; i++) begin
            d = $urandom;
            apb_xfer(1, 16'(4 * i), d, 4'hF, 3'b000, rd, e, w);
            model_write(i, d, 4'hF);
        end
        for (int n = 0; n < 60; n++) begin
            r = int'($urandom_range(0, 9));
            if (r == 0)      a = 16'($urandom_range(1024, 16383) * 4);
            else if (r == 1) a = 16'($urandom_range(0, 31) * 4 + $urandom_range(1, 3));
            else             a = 16'($urandom_range(0, 31) * 4);
            wr = 1'($urandom);
            if (wr)                           s = 4'($urandom);
            else if ($urandom_range(0, 4) == 0) s = 4'($urandom_range(1, 15));
            else                              s = 4'h0;
            p = 3'($urandom);
            d = $urandom;
            xe = exp_err(wr, a, s, p);
            apb_xfer(wr, a, d, s, p, rd, e, w);
            want = (wr || xe) ? 32'h0 : mem_m[int'(a) / 4];
            if (wr && !xe) model_write(int'(a) / 4, d, s);
            checks++;
            if (e !== xe || w !== WAITS || rd !== want) begin
                failures++;
                $display("FAIL rand%0d a=%h wr=%b s=%h p=%b got err=%b w=%0d rd=%h want %b/%0d/%h",
                         n, a, wr, s, p, e, w, rd, xe, WAITS, want);
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_strobes();
        test_errors();
        test_abort();
        test_clken();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/apb_mem_slave.md
Name: apb_mem_slave

Overview:
- APB4 completer that consumes the transfers driven on the APB bus and backs them with a word-addressed register-file memory.
- Sits directly downstream of the APB interface: it drives PREADY, PRDATA and PSLVERR back to the requester.
- Adds programmable wait states, byte-lane strobes, a secure region guarded by PPROT, and error responses for bad accesses.

Parameters:
- ADDR_WIDTH, 16, PADDR width; byte address.
- DATA_WIDTH, 32, PWDATA/PRDATA width; fixed at 32 (4 byte lanes).
- MEM_DEPTH, 1024, number of 32-bit words.
- WAIT_CYCLES, 1, PREADY-low cycles inserted in each access phase; range 0..15.
- SECURE_WORDS, 16, word indices 0..SECURE_WORDS-1 form the secure region.

Ports:
- PCLK  in  1  clock.
- PRESETn  in  1  reset: synchronous, active-low; sampled on the PCLK rising edge.
- PCLKEN  in  1  clock enable; when 0, all state and outputs hold.
- PSEL  in  1  select.
- PENABLE  in  1  access-phase indicator.
- PWRITE  in  1  1 = write, 0 = read.
- PADDR  in  ADDR_WIDTH  byte address.
- PWDATA  in  32  write data.
- PSTRB  in  4  write byte strobes.
- PPROT  in  3  protection; bit 1 = 1 means non-secure.
- PREADY  out  1  transfer completes when high in the access phase.
- PRDATA  out  32  read data; valid while PREADY=1.
- PSLVERR  out  1  error response; valid only while PREADY=1.

Behaviour:
- Clocking and reset: all logic on PCLK rising edge.
  - PRESETn=0 (synchronous): state=IDLE, PREADY=0, PRDATA=0, PSLVERR=0, wait counter=0.
  - Memory contents are not reset.
  - Reset takes priority over PCLKEN.
  - Reset mid-transfer abandons the transfer; no write is committed.
- PCLKEN=0: FSM, counter, latches, outputs and memory all hold.
- States: IDLE, ACCESS.
- IDLE, on edge with PSEL=1 and PENABLE=0 (setup phase):
  - Latch PADDR, PWRITE, PWDATA, PSTRB and PPROT.
  - Compute the error flag (see error rules); load counter=WAIT_CYCLES; go to ACCESS.
  - If WAIT_CYCLES=0, assert PREADY at this same edge, so it is high in the first access cycle.
- ACCESS, counter>0 with PSEL=1 and PENABLE=1: decrement the counter.
  - When the counter goes 1->0, assert PREADY.
  - Also drive PSLVERR = error flag.
  - Also drive PRDATA = mem[idx] for a read with no error; otherwise PRDATA = 0.
- ACCESS, PREADY=1 with PSEL=1 and PENABLE=1 (completion edge):
  - Write with no error: commit bytes of PWDATA_latched where PSTRB_latched[i]=1.
  - Deassert PREADY, PSLVERR and PRDATA (to 0); return to IDLE.
  - A new setup phase is accepted from the next edge, so back-to-back transfers take 2+WAIT_CYCLES cycles each.
- ACCESS with PSEL=0 (protocol abort): return to IDLE; clear outputs; no write.
- Ignore any change of PADDR/PWDATA during the access phase; latched values are used.
- Index: idx = PADDR[ADDR_WIDTH-1:2].
- Error rules; any one sets PSLVERR, and an errored write leaves memory unchanged:
  - PADDR[1:0] != 0 (misaligned).
  - idx >= MEM_DEPTH.
  - PPROT[1]=1 and idx < SECURE_WORDS.
  - Read with PSTRB != 0.
- Write with PSTRB=0: completes OKAY; memory unchanged.
- Read-after-write to the same word in consecutive transfers returns the new data; no forwarding hazard, since the commit precedes the next setup.

Test Plan:
- Reset: hold PRESETn=0 for 3 cycles with PSEL=1 -> PREADY=0, PRDATA=0, PSLVERR=0 throughout; FSM idle after release.
- Write/read, WAIT_CYCLES=1:
  - Write 0xDEADBEEF to PADDR 0x0040, PSTRB=4'hF, PPROT=3'b000 -> PREADY low for 1 access cycle, then high; PSLVERR=0.
  - Read 0x0040 -> PRDATA=0xDEADBEEF together with PREADY=1.
- Byte strobes: after the above, write 0x11223344 to 0x0040 with PSTRB=4'b0101 -> read returns 0xDE22BE44.
- Errors, one transfer each, each giving PSLVERR=1 with PREADY and leaving memory unchanged:
  - Write to 0x0042 (misaligned).
  - Write to 0x1000 (idx 1024, out of range).
  - Non-secure write (PPROT=3'b010) to 0x0008.
  - Read with PSTRB=4'h1.
  - Check: read of 0x0008 with PPROT=0 returns its prior value.
- Abort and PCLKEN:
  - Deassert PSEL mid-wait on a write to 0x0080 -> no commit; FSM returns to IDLE.
  - Hold PCLKEN=0 for 5 cycles during ACCESS -> PREADY timing shifts by exactly 5 cycles.
